vx_csa_tree: RTL and testbench

Pipelined, parametrised multi-operand adder that reduces N operands of W bits to one exact sum. It uses a tree of registered 4:2 compressor levels followed by a registered final carry-propagate adder. It adds per-operand masking, signed/unsigned extension, a tag side-channel and a valid/ready handshake with backpressure. It sits in datapaths that need wide dot-product or accumulation sums, such as FPU mantissa accumulation, tensor/dot units and address-sum logic.

---
 rtl/vx_csa_tree_if.sv | 29 ++
 rtl/vx_csa_tree.sv | 154 +++++++++++++++
 tb/tb_vx_csa_tree.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_csa_tree_if.sv
// Operand/result channel of vx_csa_tree: upstream beat (valid/ready/data/mask/tag)
// and downstream result (valid/ready/data/tag).
interface vx_csa_tree_if #(
    parameter int N         = 8,
    parameter int W         = 16,
    parameter int TAG_WIDTH = 1
);
    localparam int WO = W + $clog2(N);

    logic                 valid_in;
    logic                 ready_in;
    logic [N*W-1:0]       data_in;
    logic [N-1:0]         mask_in;
    logic [TAG_WIDTH-1:0] tag_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [WO-1:0]        data_out;
    logic [TAG_WIDTH-1:0] tag_out;

    modport slave (
        input  valid_in, data_in, mask_in, tag_in, ready_out,
        output ready_in, valid_out, data_out, tag_out
    );

    modport master (
        output valid_in, data_in, mask_in, tag_in, ready_out,
        input  ready_in, valid_out, data_out, tag_out
    );
endinterface

// File: rtl/vx_csa_tree.sv
// Pipelined N-operand adder: registered 4:2 compressor levels reduce the masked,
// extended operands to two rows, then a registered carry-propagate add.
module vx_csa_tree #(
    parameter int N         = 8,
    parameter int W         = 16,
    parameter bit SIGNED    = 1'b0,
    parameter int TAG_WIDTH = 1
) (
    input  logic          clk,
    input  logic          reset,
    vx_csa_tree_if.slave  bus
);
    localparam int WO = W + $clog2(N);

    function automatic int next_rows(input int r);
        return 2 * (r / 4) + (((r % 4) == 3) ? 2 : (r % 4));
    endfunction

    function automatic int rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) r = next_rows(r);
        return r;
    endfunction

    function automatic int num_levels(input int n);
        int r;
        int cnt;
        r   = n;
        cnt = 0;
        while (r > 2) begin
            r   = next_rows(r);
            cnt = cnt + 1;
        end
        return cnt;
    endfunction

    localparam int L = num_levels(N);

    // Full-adder row: returns {carry row already shifted left, sum row}.
    function automatic logic [2*WO-1:0] csa32(input logic [WO-1:0] a, input logic [WO-1:0] b,
                                              input logic [WO-1:0] c);
        logic [WO-1:0] cy;
        cy = (a & b) | (a & c) | (b & c);
        return {cy[WO-2:0], 1'b0, a ^ b ^ c};
    endfunction

    // 4:2 compressor as two cascaded full-adder rows; the first row's carry is the
    // horizontal carry into the second, so the chain starts at 0 in bit 0.
    function automatic logic [2*WO-1:0] comp42(input logic [WO-1:0] a, input logic [WO-1:0] b,
                                               input logic [WO-1:0] c, input logic [WO-1:0] d);
        logic [2*WO-1:0] first;
        first = csa32(a, b, c);
        return csa32(first[WO-1:0], d, first[2*WO-1:WO]);
    endfunction

    logic                 enable_s;
    logic [N*WO-1:0]      ext_s;
    logic [2*WO-1:0]      last_s;
    logic [L:0]           valid_r;
    logic [TAG_WIDTH-1:0] tag_r [L+1];
    logic [WO-1:0]        sum_r;

    assign enable_s      = bus.ready_out | ~valid_r[L];
    assign bus.ready_in  = enable_s;
    assign bus.valid_out = valid_r[L];
    assign bus.tag_out   = tag_r[L];
    assign bus.data_out  = sum_r;

    // Mask and extend every operand to the full output width.
    always_comb begin
        ext_s = {(N*WO){1'b0}};
        for (int i = 0; i < N; i++) begin
            if (bus.mask_in[i]) begin
                if (SIGNED) begin
                    ext_s[i*WO +: WO] = {{(WO-W){bus.data_in[i*W+W-1]}}, bus.data_in[i*W +: W]};
                end else begin
                    ext_s[i*WO +: WO] = {{(WO-W){1'b0}}, bus.data_in[i*W +: W]};
                end
            end else begin
                ext_s[i*WO +: WO] = {WO{1'b0}};
            end
        end
    end

    for (genvar l = 1; l <= L; l++) begin : g_lvl
        localparam int R_IN  = rows_at(N, l - 1);
        localparam int R_OUT = rows_at(N, l);
        localparam int NG4   = R_IN / 4;
        localparam int REM   = R_IN % 4;

        logic [R_IN*WO-1:0]  prev_s;
        logic [R_OUT*WO-1:0] comp_s;
        logic [R_OUT*WO-1:0] stage_r;

        if (l == 1) begin : g_src
            assign prev_s = ext_s;
        end else begin : g_src
            assign prev_s = g_lvl[l-1].stage_r;
        end

        for (genvar g = 0; g < NG4; g++) begin : g_c42
            assign comp_s[2*g*WO +: 2*WO] = comp42(prev_s[(4*g)*WO +: WO], prev_s[(4*g+1)*WO +: WO],
                                                   prev_s[(4*g+2)*WO +: WO], prev_s[(4*g+3)*WO +: WO]);
        end

        if (REM == 3) begin : g_rem
            assign comp_s[2*NG4*WO +: 2*WO] = csa32(prev_s[(4*NG4)*WO +: WO],
                                                    prev_s[(4*NG4+1)*WO +: WO],
                                                    prev_s[(4*NG4+2)*WO +: WO]);
        end else if (REM != 0) begin : g_rem
            assign comp_s[2*NG4*WO +: REM*WO] = prev_s[4*NG4*WO +: REM*WO];
        end

        // Level register; holds while the pipeline is stalled.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_r <= {(R_OUT*WO){1'b0}};
            end else if (enable_s) begin
                stage_r <= comp_s;
            end
        end
    end

    if (L == 0) begin : g_last
        assign last_s = ext_s;
    end else begin : g_last
        assign last_s = g_lvl[L].stage_r;
    end

    // Final carry-propagate add into the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r <= {WO{1'b0}};
        end else if (enable_s) begin
            sum_r <= last_s[WO-1:0] + last_s[2*WO-1:WO];
        end
    end

    // Valid and tag shift alongside the data stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= {(L+1){1'b0}};
            for (int i = 0; i <= L; i++) tag_r[i] <= {TAG_WIDTH{1'b0}};
        end else if (enable_s) begin
            valid_r[0] <= bus.valid_in & enable_s;
            tag_r[0]   <= bus.tag_in;
            for (int i = 1; i <= L; i++) begin
                valid_r[i] <= valid_r[i-1];
                tag_r[i]   <= tag_r[i-1];
            end
        end
    end
endmodule

// File: tb/tb_vx_csa_tree.sv
// Bench for vx_csa_tree: seven parameterisations behind a selectable port mux,
// directed scenarios plus randomized streams checked against an arithmetic model.
module tb_vx_csa_tree;
    logic         clk;
    logic         reset;
    logic [2:0]   sel;
    logic         drv_valid;
    logic         drv_ready_out;
    logic [127:0] drv_data;
    logic [15:0]  drv_mask;
    logic [3:0]   drv_tag;

    logic [6:0]      vo_all;
    logic [6:0]      ri_all;
    logic [7*32-1:0] do_all;
    logic [7*4-1:0]  to_all;

    logic        cur_valid_out;
    logic        cur_ready_in;
    logic [31:0] cur_data_out;
    logic [3:0]  cur_tag_out;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int cfg_n(input int k);
        case (k)
            0: return 4;  1: return 4;  2: return 8;  3: return 5;
            4: return 2;  5: return 3;  default: return 16;
        endcase
    endfunction

    function automatic int cfg_w(input int k);
        case (k)
            2: return 16;
            3: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit cfg_s(input int k);
        return (k == 1) || (k == 4) || (k == 6);
    endfunction

    // Cycles from acceptance to result: levels + 1 (N=2:0, 3:1, 4:1, 5:2, 8:2, 16:3).
    function automatic int cfg_lat(input int k);
        case (k)
            0: return 2;  1: return 2;  2: return 3;  3: return 3;
            4: return 1;  5: return 2;  default: return 4;
        endcase
    endfunction

    // Reference: integer sum of the masked (signed or unsigned) operands, modulo 2^WO.
    function automatic logic [31:0] ref_sum(input int k, input logic [127:0] d, input logic [15:0] m);
        int     n, w, wo;
        longint total, v;
        n = cfg_n(k);
        w = cfg_w(k);
        wo = w + $clog2(n);
        total = 0;
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                v = longint'((d >> (i * w)) & ((128'd1 << w) - 128'd1));
                if (cfg_s(k) && v[w-1]) v = v - (longint'(1) << w);
                total += v;
            end
        end
        return 32'(total & ((longint'(1) << wo) - 1));
    endfunction

    always #5 clk = ~clk;

    for (genvar k = 0; k < 7; k++) begin : g_dut
        localparam int NK = cfg_n(k);
        localparam int WK = cfg_w(k);
        localparam bit SK = cfg_s(k);

        vx_csa_tree_if #(.N(NK), .W(WK), .TAG_WIDTH(4)) bus ();

        assign bus.valid_in  = (sel == k) & drv_valid;
        assign bus.data_in   = drv_data[NK*WK-1:0];
        assign bus.mask_in   = drv_mask[NK-1:0];
        assign bus.tag_in    = drv_tag;
        assign bus.ready_out = drv_ready_out;

        assign vo_all[k]          = bus.valid_out;
        assign ri_all[k]          = bus.ready_in;
        assign do_all[k*32 +: 32] = 32'(bus.data_out);
        assign to_all[k*4 +: 4]   = bus.tag_out;

        vx_csa_tree #(.N(NK), .W(WK), .SIGNED(SK), .TAG_WIDTH(4)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    assign cur_valid_out = vo_all[sel];
    assign cur_ready_in  = ri_all[sel];
    assign cur_data_out  = do_all[sel*32 +: 32];
    assign cur_tag_out   = to_all[sel*4 +: 4];

    // Present one beat and report how many edges until its result shows (-1 if never).
    task automatic send_one(input logic [127:0] d, input logic [15:0] m, input logic [3:0] t,
                            output int lat, output logic [31:0] dout, output logic [3:0] tout);
        @(negedge clk);
        drv_data = d; drv_mask = m; drv_tag = t; drv_valid = 1'b1; drv_ready_out = 1'b1;
        lat = -1; dout = 32'd0; tout = 4'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            drv_valid = 1'b0;
            if (cur_valid_out && lat < 0) begin
                lat = c; dout = cur_data_out; tout = cur_tag_out;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            sel = 3'(k);
            #1;
            n_checks += 3;
            if (cur_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid cfg %0d: got %b expected 0", k, cur_valid_out); end
            if (cur_data_out !== 32'd0 || cur_tag_out !== 4'd0) begin
                n_fail++; $display("FAIL reset_data cfg %0d: got %0h/%0h expected 0/0", k, cur_data_out, cur_tag_out);
            end
            if (cur_ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready cfg %0d: got %b expected 1", k, cur_ready_in); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unsigned_sum();
        int lat; logic [31:0] d; logic [3:0] t;
        sel = 3'd0;
        send_one(128'hFFFF_FFFF, 16'hF, 4'h1, lat, d, t);
        n_checks += 3;
        if (lat != 2) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected 2", lat); end
        if (d !== 32'd1020) begin n_fail++; $display("FAIL unsigned_sum: got %0d expected 1020", d); end
        if (t !== 4'h1) begin n_fail++; $display("FAIL unsigned_tag: got %0h expected 1", t); end
    endtask

    task automatic test_signed_sum();
        int lat; logic [31:0] d; logic [3:0] t;
        sel = 3'd1;
        send_one(128'h8080_8080, 16'hF, 4'h2, lat, d, t);
        n_checks += 2;
        if (lat != 2) begin n_fail++; $display("FAIL signed_latency: got %0d expected 2", lat); end
        if (d !== 32'h200) begin n_fail++; $display("FAIL signed_min: got %0h expected 200", d); end
        send_one(128'hFF01_807F, 16'hF, 4'h3, lat, d, t);
        n_checks += 2;
        if (d !== 32'h3FF) begin n_fail++; $display("FAIL signed_mixed: got %0h expected 3ff", d); end
        if (t !== 4'h3) begin n_fail++; $display("FAIL signed_tag: got %0h expected 3", t); end
    endtask

    task automatic test_masking();
        int lat; logic [31:0] d; logic [3:0] t; logic [127:0] ops;
        sel = 3'd2;
        ops = 128'd0;
        for (int i = 0; i < 8; i++) ops[i*16 +: 16] = 16'(i + 1);
        send_one(ops, 16'b1010_1010, 4'h5, lat, d, t);
        n_checks += 2;
        if (lat != 3) begin n_fail++; $display("FAIL mask_latency: got %0d expected 3", lat); end
        if (d !== 32'd20) begin n_fail++; $display("FAIL mask_sum: got %0d expected 20", d); end
    endtask

    task automatic test_backpressure();
        int sent, got, hold; bit seen, acc;
        sel = 3'd2; drv_ready_out = 1'b1; drv_valid = 1'b0; drv_mask = 16'hFF;
        sent = 0; got = 0; hold = 0; seen = 1'b0; acc = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
            @(negedge clk);
            if (acc) begin drv_valid = 1'b0; acc = 1'b0; end
            if (cur_valid_out && !seen) begin seen = 1'b1; hold = 4; end
            drv_ready_out = (hold == 0);
            if (!drv_valid && sent < 6) begin
                drv_valid = 1'b1; drv_data = {8{16'(10 + sent)}}; drv_tag = 4'(sent);
            end
            #1;
            if (hold > 0) begin
                n_checks += 2;
                if (cur_ready_in !== 1'b0) begin n_fail++; $display("FAIL bp_ready_in: got %b expected 0", cur_ready_in); end
                if (cur_data_out !== 32'd80) begin n_fail++; $display("FAIL bp_hold_data: got %0d expected 80", cur_data_out); end
                hold--;
            end
            if (drv_valid && cur_ready_in) begin sent++; acc = 1'b1; end
            if (cur_valid_out && drv_ready_out) begin
                n_checks += 2;
                if (cur_data_out !== 32'(8 * (10 + got))) begin
                    n_fail++; $display("FAIL bp_order: got %0d expected %0d", cur_data_out, 8 * (10 + got));
                end
                if (cur_tag_out !== 4'(got)) begin n_fail++; $display("FAIL bp_tag: got %0d expected %0d", cur_tag_out, got); end
                got++;
            end
        end
        drv_valid = 1'b0; drv_ready_out = 1'b1;
        n_checks++;
        if (got != 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got); end
    endtask

    task automatic test_reset_midflight();
        int lat; logic [31:0] d; logic [3:0] t;
        sel = 3'd3; drv_ready_out = 1'b1; drv_mask = 16'h1F;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            drv_valid = 1'b1; drv_data = {96'd0, $urandom}; drv_tag = 4'(b + 8);
        end
        @(negedge clk);
        drv_valid = 1'b0;
        n_checks++;
        if (cur_valid_out !== 1'b1) begin n_fail++; $display("FAIL midflight_valid: got %b expected 1", cur_valid_out); end
        #2 reset = 1'b1;
        #1;
        n_checks += 3;
        if (cur_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", cur_valid_out); end
        if (cur_data_out !== 32'd0 || cur_tag_out !== 4'd0) begin
            n_fail++; $display("FAIL rst_async_data: got %0h/%0h expected 0/0", cur_data_out, cur_tag_out);
        end
        if (cur_ready_in !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready: got %b expected 1", cur_ready_in); end
        @(negedge clk);
        reset = 1'b0;
        send_one(128'h1_1111, 16'h1F, 4'h9, lat, d, t);
        n_checks += 3;
        if (lat != 3) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 3", lat); end
        if (d !== 32'd5) begin n_fail++; $display("FAIL post_rst_sum: got %0d expected 5", d); end
        if (t !== 4'h9) begin n_fail++; $display("FAIL post_rst_tag: got %0h expected 9", t); end
    endtask

    task automatic test_random_stream();
        int cfgs[4] = '{4, 5, 3, 6};
        for (int ci = 0; ci < 4; ci++) begin
            logic [31:0] q_data[$];
            logic [3:0]  q_tag[$];
            logic [31:0] exp_d;
            logic [3:0]  exp_t;
            int sent, got; bit acc;
            sel = 3'(cfgs[ci]); sent = 0; got = 0; acc = 1'b0; drv_valid = 1'b0;
            for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
                @(negedge clk);
                if (acc) begin drv_valid = 1'b0; acc = 1'b0; end
                if (!drv_valid && sent < 40 && $urandom_range(3) != 0) begin
                    drv_valid = 1'b1;
                    drv_data  = {$urandom, $urandom, $urandom, $urandom};
                    drv_mask  = 16'($urandom);
                    drv_tag   = 4'(sent);
                end
                drv_ready_out = ($urandom_range(2) != 0);
                #1;
                if (drv_valid && cur_ready_in) begin
                    q_data.push_back(ref_sum(cfgs[ci], drv_data, drv_mask));
                    q_tag.push_back(drv_tag);
                    sent++; acc = 1'b1;
                end
                if (cur_valid_out && drv_ready_out) begin
                    n_checks++;
                    if (q_data.size() == 0) begin
                        n_fail++; $display("FAIL rand_spurious cfg %0d: got %0h expected no result", cfgs[ci], cur_data_out);
                    end else begin
                        exp_d = q_data.pop_front();
                        exp_t = q_tag.pop_front();
                        if (cur_data_out !== exp_d) begin
                            n_fail++; $display("FAIL rand_sum cfg %0d: got %0h expected %0h", cfgs[ci], cur_data_out, exp_d);
                        end
                        n_checks++;
                        if (cur_tag_out !== exp_t) begin
                            n_fail++; $display("FAIL rand_tag cfg %0d: got %0h expected %0h", cfgs[ci], cur_tag_out, exp_t);
                        end
                    end
                    got++;
                end
            end
            drv_valid = 1'b0; drv_ready_out = 1'b1;
            n_checks++;
            if (got != 40) begin n_fail++; $display("FAIL rand_count cfg %0d: got %0d expected 40", cfgs[ci], got); end
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; sel = 3'd0;
        drv_valid = 1'b0; drv_ready_out = 1'b1; drv_data = 128'd0; drv_mask = 16'd0; drv_tag = 4'd0;
        test_reset();
        test_unsigned_sum();
        test_signed_sum();
        test_masking();
        test_backpressure();
        test_reset_midflight();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
